uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-input handshake and transmitter status bundle for uart_tx_fifo.
//   i_data  : byte offered by the producer
//   i_valid : i_data is valid this cycle
//   o_ready : transmitter FIFO can take a byte this cycle
//   o_tx    : serial line (idles high)
//   o_busy  : frame in flight or bytes still queued
//   o_count : bytes currently held in the FIFO
// master = producer side, slave = the transmitter.
interface uart_tx_fifo_if #(
  parameter int CNT_W = 3
);
  logic [7:0]       i_data;
  logic             i_valid;
  logic             o_ready;
  logic             o_tx;
  logic             o_busy;
  logic [CNT_W-1:0] o_count;

  modport master (
    output i_data, i_valid,
    input  o_ready, o_tx, o_busy, o_count
  );

  modport slave (
    input  i_data, i_valid,
    output o_ready, o_tx, o_busy, o_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first) fed by a small FIFO with a valid/ready
// byte input.
//   clk   : system clock, all logic on the rising edge
//   rst_n : asynchronous active-low reset; line returns high at once and
//           queued bytes and any partial frame are dropped
//   bus   : uart_tx_fifo_if.slave (i_data/i_valid in; o_ready, o_tx,
//           o_busy, o_count out)
// CLK_DIV is clocks per bit (2..65535), FIFO_DEPTH a power of two (2..16).
module uart_tx_fifo #(
  parameter  int CLK_DIV    = 87,
  parameter  int FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam int               PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [15:0]      BAUD_LAST  = 16'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_reg, state_next;
  logic [15:0]      baud_reg, baud_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             busy_reg, busy_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [7:0]       mem [FIFO_DEPTH];

  logic ready;
  logic push;
  logic pop;
  logic bit_end;
  logic fifo_nonempty;

  // Full/empty come from the occupancy count alone; the pointers simply
  // wrap modulo FIFO_DEPTH.
  assign ready         = (count_reg != COUNT_FULL);
  assign fifo_nonempty = (count_reg != '0);
  assign push          = bus.i_valid && ready;
  assign bit_end       = (baud_reg == BAUD_LAST);

  // Storage has no reset: dropping the pointers/count discards contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.i_data;
    end
  end

  // Frame sequencer. A pop loads the head byte straight into the shift
  // register; STOP can chain directly into START so queued bytes go out
  // back to back.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (fifo_nonempty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg];
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next  = '0;
          shift_next = shift_reg >> 1;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next = '0;
          if (fifo_nonempty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr_reg];
            bit_next   = '0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Line and busy are computed from next-state values so the registered
  // outputs change on the same edge as the state they describe.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE) || (count_next != '0);
    if (state_next == START) begin
      tx_next = 1'b0;
    end else if (state_next == DATA) begin
      tx_next = shift_next[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_tx    = tx_reg;
  assign bus.o_busy  = busy_reg;
  assign bus.o_count = count_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: one instance with CLK_DIV=4 for the directed
// scenarios and one with CLK_DIV=2 for the long random run. A line-level
// UART receiver model decodes every frame from o_tx independently.
module tb_uart_tx_fifo;
  localparam int DIV_A = 4;
  localparam int DIV_B = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int WAIT_MAX = 5000;

  typedef struct {
    logic [7:0] data;
    bit         frame_ok;
    int         start_cyc;
  } rx_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   peak [2];
  int   rdy_bad [2];
  rx_t  rx_a [$];
  rx_t  rx_b [$];
  rx_t  r_a, r_b;
  bit   got_a, got_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if #(.CNT_W(CNT_W)) bus_a ();
  uart_tx_fifo_if #(.CNT_W(CNT_W)) bus_b ();

  uart_tx_fifo #(.CLK_DIV(DIV_A), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  uart_tx_fifo #(.CLK_DIV(DIV_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  function automatic logic txv(input bit sel);
    return sel ? bus_b.o_tx : bus_a.o_tx;
  endfunction
  function automatic logic rdy(input bit sel);
    return sel ? bus_b.o_ready : bus_a.o_ready;
  endfunction
  function automatic logic busy(input bit sel);
    return sel ? bus_b.o_busy : bus_a.o_busy;
  endfunction
  function automatic logic [CNT_W-1:0] cnt(input bit sel);
    return sel ? bus_b.o_count : bus_a.o_count;
  endfunction

  // Reference receiver: start bit found on a low sample, every bit sampled
  // mid-cell; a frame cut by reset is discarded.
  task automatic rx_frame(input bit sel, input int div, output rx_t r, output bit got);
    bit aborted = 1'b0;
    got = 1'b0;
    r.data = '0;
    r.frame_ok = 1'b1;
    r.start_cyc = 0;
    @(negedge clk);
    if (!rst_n || txv(sel) !== 1'b0) return;
    r.start_cyc = cyc;
    for (int j = 0; j < 10; j++) begin
      while (cyc < r.start_cyc + j * div + div / 2) begin
        @(negedge clk);
        if (!rst_n) aborted = 1'b1;
      end
      if (j == 0) begin
        if (txv(sel) !== 1'b0) r.frame_ok = 1'b0;
      end else if (j < 9) begin
        r.data[j-1] = txv(sel);
      end else if (txv(sel) !== 1'b1) begin
        r.frame_ok = 1'b0;
      end
    end
    got = !aborted;
  endtask

  initial forever begin
    rx_frame(1'b0, DIV_A, r_a, got_a);
    if (got_a) rx_a.push_back(r_a);
  end
  initial forever begin
    rx_frame(1'b1, DIV_B, r_b, got_b);
    if (got_b) rx_b.push_back(r_b);
  end

  // Occupancy bookkeeping, sampled at each negedge the stimulus passes.
  task automatic note(input bit sel);
    if (int'(cnt(sel)) > peak[sel]) peak[sel] = int'(cnt(sel));
    if (rdy(sel) !== (cnt(sel) != CNT_W'(DEPTH))) rdy_bad[sel]++;
  endtask

  task automatic drive(input bit sel, input logic [7:0] d, input logic v);
    if (sel) begin bus_b.i_data = d; bus_b.i_valid = v; end
    else begin bus_a.i_data = d; bus_a.i_valid = v; end
  endtask

  // Called at a negedge; offers d until accepted. pc = edge of the push;
  // returns at the negedge right after that edge.
  task automatic push(input bit sel, input logic [7:0] d, output int pc, output bit ok);
    int w = 0;
    drive(sel, d, 1'b1);
    while (rdy(sel) !== 1'b1 && w < WAIT_MAX) begin
      note(sel);
      @(negedge clk);
      w++;
    end
    ok = (w < WAIT_MAX);
    note(sel);
    pc = cyc + 1;
    @(negedge clk);
    drive(sel, 8'($urandom), 1'b0);
  endtask

  task automatic push_seq(input bit sel, input logic [7:0] b[$], output int pcs[$], output bit ok);
    int pc;
    bit ok1;
    ok = 1'b1;
    pcs = {};
    foreach (b[i]) begin
      push(sel, b[i], pc, ok1);
      pcs.push_back(pc);
      ok &= ok1;
    end
  endtask

  task automatic wait_idle(input bit sel, output bit ok, output int when);
    int w = 0;
    while (busy(sel) !== 1'b0 && w < WAIT_MAX) begin
      note(sel);
      @(negedge clk);
      w++;
    end
    note(sel);
    ok = (w < WAIT_MAX);
    when = cyc;
  endtask

  task automatic test_reset();
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (txv(0) !== 1'b1) begin bad++; $display("FAIL rst_hold_tx: got %b want 1", txv(0)); end
    total++; if (rdy(0) !== 1'b1) begin bad++; $display("FAIL rst_hold_ready: got %b want 1", rdy(0)); end
    total++; if (busy(0) !== 1'b0) begin bad++; $display("FAIL rst_hold_busy: got %b want 0", busy(0)); end
    total++; if (cnt(0) !== '0) begin bad++; $display("FAIL rst_hold_count: got %0d want 0", cnt(0)); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (txv(0) !== 1'b1 || txv(1) !== 1'b1) begin bad++; $display("FAIL rst_rel_tx: got %b/%b want 1/1", txv(0), txv(1)); end
    total++; if (rdy(0) !== 1'b1 || rdy(1) !== 1'b1) begin bad++; $display("FAIL rst_rel_ready: got %b/%b want 1/1", rdy(0), rdy(1)); end
    total++; if (busy(0) !== 1'b0) begin bad++; $display("FAIL rst_rel_busy: got %b want 0", busy(0)); end
    total++; if (cnt(0) !== '0) begin bad++; $display("FAIL rst_rel_count: got %0d want 0", cnt(0)); end
    $display("reset: released at cycle %0d", cyc);
  endtask

  task automatic test_single_frame();
    logic [7:0] d;
    logic exp_tx, exp_busy;
    int pc, base, idx;
    bit ok;
    d = 8'h55;
    base = rx_a.size();
    push(1'b0, d, pc, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_push: accepted=0 want 1"); end
    total++; if (cnt(0) !== CNT_W'(1)) begin bad++; $display("FAIL single_count: got %0d want 1", cnt(0)); end
    total++; if (busy(0) !== 1'b1) begin bad++; $display("FAIL single_busy_rise: got %b want 1", busy(0)); end
    total++; if (txv(0) !== 1'b1) begin bad++; $display("FAIL single_tx_idle: got %b want 1", txv(0)); end
    for (int k = 1; k <= 10 * DIV_A + 1; k++) begin
      @(negedge clk);
      idx = (k - 1) / DIV_A;
      exp_tx = (idx == 0) ? 1'b0 : (idx <= 8) ? d[idx-1] : 1'b1;
      exp_busy = (k <= 10 * DIV_A);
      total++; if (txv(0) !== exp_tx) begin bad++; $display("FAIL single_tx k=%0d: got %b want %b", k, txv(0), exp_tx); end
      total++; if (busy(0) !== exp_busy) begin bad++; $display("FAIL single_busy k=%0d: got %b want %b", k, busy(0), exp_busy); end
    end
    total++;
    if (rx_a.size() != base + 1) begin
      bad++; $display("FAIL single_frames: got %0d want 1", rx_a.size() - base);
    end else begin
      $display("single: byte %02h start @%0d", rx_a[base].data, rx_a[base].start_cyc);
      total++;
      if (rx_a[base].data !== d || !rx_a[base].frame_ok || rx_a[base].start_cyc != pc + 1) begin
        bad++; $display("FAIL single_decode: got %02h ok=%0d @%0d want %02h ok=1 @%0d",
                        rx_a[base].data, rx_a[base].frame_ok, rx_a[base].start_cyc, d, pc + 1);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] b[$];
    int pcs[$];
    int base, t, s;
    bit ok, ok2;
    b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    base = rx_a.size();
    peak[0] = 0; rdy_bad[0] = 0;
    push_seq(1'b0, b, pcs, ok);
    wait_idle(1'b0, ok2, t);
    s = pcs[0] + 1;
    total++; if (!ok || !ok2) begin bad++; $display("FAIL burst_timeout: push_ok=%0d idle_ok=%0d want 1/1", ok, ok2); end
    total++; if (peak[0] != DEPTH) begin bad++; $display("FAIL burst_peak: got %0d want %0d", peak[0], DEPTH); end
    total++; if (rdy_bad[0] != 0) begin bad++; $display("FAIL burst_ready: %0d cycles with ready != (count!=full)", rdy_bad[0]); end
    for (int i = 1; i < 5; i++) begin
      total++; if (pcs[i] != pcs[0] + i) begin bad++; $display("FAIL burst_accept[%0d]: got @%0d want @%0d", i, pcs[i], pcs[0] + i); end
    end
    total++; if (t != s + 50 * DIV_A) begin bad++; $display("FAIL burst_idle: got @%0d want @%0d", t, s + 50 * DIV_A); end
    total++;
    if (rx_a.size() != base + 5) begin
      bad++; $display("FAIL burst_frames: got %0d want 5", rx_a.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        $display("burst: byte %02h start @%0d", rx_a[base+i].data, rx_a[base+i].start_cyc);
        total++;
        if (rx_a[base+i].data !== b[i] || !rx_a[base+i].frame_ok || rx_a[base+i].start_cyc != s + 10 * DIV_A * i) begin
          bad++; $display("FAIL burst_decode[%0d]: got %02h @%0d want %02h @%0d", i,
                          rx_a[base+i].data, rx_a[base+i].start_cyc, b[i], s + 10 * DIV_A * i);
        end
      end
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] b[$];
    int pcs[$];
    int base, t, s;
    bit ok, ok2;
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    base = rx_a.size();
    push_seq(1'b0, b, pcs, ok);
    // The sixth byte must wait for the second pop, then land one cycle later.
    s = pcs[0] + 1;
    total++; if (pcs[5] != s + 10 * DIV_A + 1) begin bad++; $display("FAIL full_accept: got @%0d want @%0d", pcs[5], s + 10 * DIV_A + 1); end
    total++; if (cnt(0) !== CNT_W'(DEPTH) || rdy(0) !== 1'b0) begin bad++; $display("FAIL full_refill: count=%0d ready=%b want %0d/0", cnt(0), rdy(0), DEPTH); end
    wait_idle(1'b0, ok2, t);
    total++; if (!ok || !ok2) begin bad++; $display("FAIL full_timeout: push_ok=%0d idle_ok=%0d want 1/1", ok, ok2); end
    total++; if (t != s + 60 * DIV_A) begin bad++; $display("FAIL full_idle: got @%0d want @%0d", t, s + 60 * DIV_A); end
    total++;
    if (rx_a.size() != base + 6) begin
      bad++; $display("FAIL full_frames: got %0d want 6", rx_a.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        $display("full: byte %02h start @%0d", rx_a[base+i].data, rx_a[base+i].start_cyc);
        total++;
        if (rx_a[base+i].data !== b[i] || !rx_a[base+i].frame_ok) begin
          bad++; $display("FAIL full_decode[%0d]: got %02h want %02h", i, rx_a[base+i].data, b[i]);
        end
      end
    end
  endtask

  task automatic test_zero_ff();
    logic [7:0] b[$];
    int pcs[$];
    logic line[$];
    int runs[$];
    int exp_runs[4];
    int base, t, n;
    logic lvl;
    bit ok, ok2;
    b = '{8'h00, 8'hFF};
    base = rx_a.size();
    push_seq(1'b0, b, pcs, ok);
    while (cyc - pcs[0] <= 20 * DIV_A) begin
      line.push_back(txv(0));
      @(negedge clk);
    end
    lvl = line[0]; n = 0;
    foreach (line[i]) begin
      if (line[i] === lvl) n++;
      else begin runs.push_back(n); lvl = line[i]; n = 1; end
    end
    runs.push_back(n);
    exp_runs = '{9 * DIV_A, DIV_A, DIV_A, 9 * DIV_A};
    total++; if (line[0] !== 1'b0) begin bad++; $display("FAIL zf_first_level: got %b want 0", line[0]); end
    total++;
    if (runs.size() != 4) begin
      bad++; $display("FAIL zf_runs: got %0d runs want 4", runs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (runs[i] != exp_runs[i]) begin bad++; $display("FAIL zf_run[%0d]: got %0d want %0d", i, runs[i], exp_runs[i]); end
      end
    end
    wait_idle(1'b0, ok2, t);
    total++; if (!ok || !ok2) begin bad++; $display("FAIL zf_timeout: push_ok=%0d idle_ok=%0d want 1/1", ok, ok2); end
    total++;
    if (rx_a.size() != base + 2) begin
      bad++; $display("FAIL zf_frames: got %0d want 2", rx_a.size() - base);
    end else begin
      for (int i = 0; i < 2; i++) begin
        $display("zero_ff: byte %02h start @%0d", rx_a[base+i].data, rx_a[base+i].start_cyc);
        total++; if (rx_a[base+i].data !== b[i] || !rx_a[base+i].frame_ok) begin bad++; $display("FAIL zf_decode[%0d]: got %02h want %02h", i, rx_a[base+i].data, b[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    int pcs[$];
    int base, errs;
    bit ok;
    b = '{8'h00, 8'h3C, 8'h5A};
    base = rx_a.size();
    push_seq(1'b0, b, pcs, ok);
    while (cyc < pcs[0] + 1 + 3 * DIV_A) @(negedge clk);
    total++; if (txv(0) !== 1'b0) begin bad++; $display("FAIL rm_pre_tx: got %b want 0", txv(0)); end
    total++; if (cnt(0) !== CNT_W'(2)) begin bad++; $display("FAIL rm_pre_count: got %0d want 2", cnt(0)); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (txv(0) !== 1'b1) begin bad++; $display("FAIL rm_tx: got %b want 1", txv(0)); end
    total++; if (cnt(0) !== '0 || rdy(0) !== 1'b1 || busy(0) !== 1'b0) begin bad++; $display("FAIL rm_state: count=%0d ready=%b busy=%b want 0/1/0", cnt(0), rdy(0), busy(0)); end
    @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    for (int k = 0; k < 12 * DIV_A; k++) begin
      @(negedge clk);
      if (txv(0) !== 1'b1 || busy(0) !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL rm_quiet: %0d active cycles after reset want 0", errs); end
    total++; if (rx_a.size() != base) begin bad++; $display("FAIL rm_frames: got %0d want 0", rx_a.size() - base); end
    $display("reset_mid: reset at cycle %0d, line quiet afterwards", cyc);
  endtask

  task automatic test_long_run();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int base, pc, t, timeouts;
    bit ok;
    base = rx_b.size();
    peak[1] = 0; rdy_bad[1] = 0; timeouts = 0;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      push(1'b1, d, pc, ok);
      if (!ok) timeouts++;
      exp_q.push_back(d);
      repeat ($urandom_range(0, 3)) begin
        note(1'b1);
        @(negedge clk);
      end
    end
    wait_idle(1'b1, ok, t);
    total++; if (timeouts != 0 || !ok) begin bad++; $display("FAIL long_timeout: push_timeouts=%0d idle_ok=%0d want 0/1", timeouts, ok); end
    total++; if (peak[1] > DEPTH) begin bad++; $display("FAIL long_peak: got %0d want <= %0d", peak[1], DEPTH); end
    total++; if (rdy_bad[1] != 0) begin bad++; $display("FAIL long_ready: %0d cycles with ready != (count!=full)", rdy_bad[1]); end
    total++;
    if (rx_b.size() != base + 256) begin
      bad++; $display("FAIL long_frames: got %0d want 256", rx_b.size() - base);
    end else begin
      foreach (exp_q[i]) begin
        $display("long[%0d]: byte %02h start @%0d", i, rx_b[base+i].data, rx_b[base+i].start_cyc);
        total++;
        if (rx_b[base+i].data !== exp_q[i] || !rx_b[base+i].frame_ok) begin
          bad++; $display("FAIL long_decode[%0d]: got %02h ok=%0d want %02h ok=1", i, rx_b[base+i].data, rx_b[base+i].frame_ok, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    peak[0] = 0; peak[1] = 0;
    rdy_bad[0] = 0; rdy_bad[1] = 0;
    test_reset();
    test_single_frame();
    test_burst();
    test_full_pop();
    test_zero_ff();
    test_reset_mid();
    test_long_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
